// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: splits the fetched word into fields, builds the immediate and control bus,
// flags illegal encodings, and registers the result behind a valid/ready skid buffer.
module riscv_decode_stage #(
    parameter int NB_WORD = 32,
    parameter int NB_PC   = 16,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               i_clock,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [NB_WORD-1:0] i_instruction,
    input  logic [NB_PC-1:0]   i_pc,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [17:0]        o_ctrl,
    output logic [4:0]         o_rs1,
    output logic [4:0]         o_rs2,
    output logic [NB_WORD-1:0] o_imm,
    output logic [NB_PC-1:0]   o_pc,
    output logic               o_branch,
    output logic               o_jump,
    output logic               o_illegal
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_RR     = 7'b0110011
    } opcode_e;

    typedef struct packed {
        logic [17:0]        ctrl;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [NB_WORD-1:0] imm;
        logic [NB_PC-1:0]   pc;
        logic               branch;
        logic               jump;
        logic               illegal;
    } entry_t;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = i_instruction[6:0];
    assign rd_f   = i_instruction[11:7];
    assign funct3 = i_instruction[14:12];
    assign rs1_f  = i_instruction[19:15];
    assign rs2_f  = i_instruction[24:20];
    assign funct7 = i_instruction[31:25];

    assign imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
    assign imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
    assign imm_b = {{20{i_instruction[31]}}, i_instruction[7], i_instruction[30:25],
                    i_instruction[11:8], 1'b0};
    assign imm_u = {i_instruction[31:12], 12'b0};
    assign imm_j = {{12{i_instruction[31]}}, i_instruction[19:12], i_instruction[20],
                    i_instruction[30:21], 1'b0};

    logic        alu_src1, alu_src2, arith_logic, dmem_rd, dmem_wr, rf_wr_op, rf_wr, wb_to_rf;
    logic        use_rs1, use_rs2, is_branch, is_jump, illegal;
    logic [2:0]  alu_op, ls_funct3;
    logic [31:0] imm_sel;
    entry_t      dec;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        alu_src1    = 1'b0;
        alu_src2    = 1'b0;
        alu_op      = 3'b000;
        arith_logic = 1'b0;
        dmem_rd     = 1'b0;
        dmem_wr     = 1'b0;
        ls_funct3   = 3'b000;
        rf_wr_op    = 1'b0;
        wb_to_rf    = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        is_branch   = 1'b0;
        is_jump     = 1'b0;
        illegal     = 1'b0;
        imm_sel     = '0;
        case (opcode)
            OP_LUI: begin
                alu_src2 = 1'b1;
                rf_wr_op = 1'b1;
                imm_sel  = imm_u;
            end
            OP_AUIPC: begin
                alu_src1 = 1'b1;
                alu_src2 = 1'b1;
                rf_wr_op = 1'b1;
                imm_sel  = imm_u;
            end
            OP_JAL: begin
                alu_src1 = 1'b1;
                alu_src2 = 1'b1;
                rf_wr_op = 1'b1;
                is_jump  = 1'b1;
                imm_sel  = imm_j;
            end
            OP_JALR: begin
                alu_src2 = 1'b1;
                rf_wr_op = 1'b1;
                is_jump  = 1'b1;
                use_rs1  = 1'b1;
                imm_sel  = imm_i;
                illegal  = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                alu_op    = funct3;
                is_branch = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                imm_sel   = imm_b;
                illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                alu_src2  = 1'b1;
                dmem_rd   = 1'b1;
                ls_funct3 = funct3;
                rf_wr_op  = 1'b1;
                wb_to_rf  = 1'b1;
                use_rs1   = 1'b1;
                imm_sel   = imm_i;
                illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                alu_src2  = 1'b1;
                dmem_wr   = 1'b1;
                ls_funct3 = funct3;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                imm_sel   = imm_s;
                illegal   = (funct3 > 3'b010);
            end
            OP_IMM: begin
                alu_src2 = 1'b1;
                alu_op   = funct3;
                rf_wr_op = 1'b1;
                use_rs1  = 1'b1;
                imm_sel  = imm_i;
                // Shift-immediates reuse funct7 as an encoding field; SRAI selects arithmetic.
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'h00);
                end else if (funct3 == 3'b101) begin
                    arith_logic = funct7[5];
                    illegal     = (funct7 != 7'h00) && (funct7 != 7'h20);
                end
            end
            OP_RR: begin
                alu_op      = funct3;
                arith_logic = funct7[5];
                rf_wr_op    = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                illegal     = !((funct7 == 7'h00) ||
                                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default: illegal = 1'b1;
        endcase

        rf_wr       = rf_wr_op && (rd_f != 5'd0);
        dec.ctrl    = {alu_src1, alu_src2, alu_op, arith_logic, (rf_wr ? rd_f : 5'd0),
                       dmem_rd, dmem_wr, ls_funct3, rf_wr, wb_to_rf};
        dec.rs1     = use_rs1 ? rs1_f : 5'd0;
        dec.rs2     = use_rs2 ? rs2_f : 5'd0;
        dec.imm     = NB_WORD'($signed(imm_sel));
        dec.pc      = i_pc;
        dec.branch  = is_branch;
        dec.jump    = is_jump;
        dec.illegal = illegal;
        if (illegal) begin
            dec.ctrl   = '0;
            dec.imm    = '0;
            dec.branch = 1'b0;
            dec.jump   = 1'b0;
        end
    end

    entry_t main_q, skid_q;
    logic   main_valid, skid_valid;
    logic   accept, consume;

    // Skid mode takes ready from a flop so it never combinationally depends on i_out_ready.
    assign o_in_ready = SKID_EN ? !skid_valid : (!main_valid || i_out_ready);
    assign accept     = i_in_valid && o_in_ready;
    assign consume    = main_valid && i_out_ready;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: data registers are reset as well, so every output reads 0 out of reset.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (i_flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume || !main_valid) begin
            // NOTE: non-blocking updates so every flop here sees the pre-edge state.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept && SKID_EN) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign o_out_valid = main_valid;
    assign o_ctrl      = main_q.ctrl;
    assign o_rs1       = main_q.rs1;
    assign o_rs2       = main_q.rs2;
    assign o_imm       = main_q.imm;
    assign o_pc        = main_q.pc;
    assign o_branch    = main_q.branch;
    assign o_jump      = main_q.jump;
    assign o_illegal   = main_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: a skid instance and a single-entry instance share one stimulus
// stream; each is compared every cycle against a queue-based reference model.
module tb_riscv_decode_stage;

    typedef struct packed {
        logic [17:0] ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [15:0] pc;
        logic        branch;
        logic        jump;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [15:0] pc = '0;

    logic        rdy1, vld1, br1, jp1, il1;
    logic [17:0] ctrl1;
    logic [4:0]  rs1_1, rs2_1;
    logic [31:0] imm1;
    logic [15:0] pc1;
    logic        rdy0, vld0, br0, jp0, il0;
    logic [17:0] ctrl0;
    logic [4:0]  rs1_0, rs2_0;
    logic [31:0] imm0;
    logic [15:0] pc0;

    always #5 clk = ~clk;

    riscv_decode_stage #(.NB_WORD(32), .NB_PC(16), .SKID_EN(1'b1)) dut_skid (
        .i_clock(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(rdy1), .i_instruction(instr), .i_pc(pc), .o_out_valid(vld1),
        .i_out_ready(out_ready), .o_ctrl(ctrl1), .o_rs1(rs1_1), .o_rs2(rs2_1),
        .o_imm(imm1), .o_pc(pc1), .o_branch(br1), .o_jump(jp1), .o_illegal(il1)
    );

    riscv_decode_stage #(.NB_WORD(32), .NB_PC(16), .SKID_EN(1'b0)) dut_single (
        .i_clock(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(rdy0), .i_instruction(instr), .i_pc(pc), .o_out_valid(vld0),
        .i_out_ready(out_ready), .o_ctrl(ctrl0), .o_rs1(rs1_0), .o_rs2(rs2_0),
        .o_imm(imm0), .o_pc(pc0), .o_branch(br0), .o_jump(jp0), .o_illegal(il0)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    exp_t        q1[$];
    exp_t        q0[$];
    logic [15:0] obs1[$];
    logic [15:0] obs0[$];
    bit          acc1_last, acc0_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: immediates come from arithmetic shifts of the whole word, control bits
    // from per-opcode rules, legality from the allowed funct3/funct7 sets.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [15:0] p);
        exp_t        e;
        int          f3, f7, rd, c, wr_rd;
        int          known, legal, src1, src2, writes, mrd, mwr, uses1, uses2, br, jmp;
        int          arith, aluop, lsf3;
        logic [31:0] imm, ii, ss, bb, uu, jj;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        rd = int'(w[11:7]);
        ii = 32'($signed(w) >>> 20);
        ss = (ii & ~32'h1F) | 32'(w[11:7]);
        bb = (32'($signed(w) >>> 19) & 32'hFFFF_F000) | (32'(w[7]) << 11) |
             (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        uu = w & 32'hFFFF_F000;
        jj = (32'($signed(w) >>> 11) & 32'hFFF0_0000) | (w & 32'h000F_F000) |
             (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        known = 1; legal = 1; src1 = 0; src2 = 0; writes = 0; mrd = 0; mwr = 0;
        uses1 = 0; uses2 = 0; br = 0; jmp = 0; arith = 0; aluop = 0; lsf3 = 0; imm = '0;
        case (w[6:0])
            7'h37: begin src2 = 1; writes = 1; imm = uu; end
            7'h17: begin src1 = 1; src2 = 1; writes = 1; imm = uu; end
            7'h6F: begin src1 = 1; src2 = 1; writes = 1; jmp = 1; imm = jj; end
            7'h67: begin src2 = 1; writes = 1; jmp = 1; uses1 = 1; imm = ii; legal = int'(f3 == 0); end
            7'h63: begin
                br = 1; aluop = f3; uses1 = 1; uses2 = 1; imm = bb;
                legal = int'(f3 != 2 && f3 != 3);
            end
            7'h03: begin
                src2 = 1; writes = 1; mrd = 1; lsf3 = f3; uses1 = 1; imm = ii;
                legal = int'(f3 inside {0, 1, 2, 4, 5});
            end
            7'h23: begin
                src2 = 1; mwr = 1; lsf3 = f3; uses1 = 1; uses2 = 1; imm = ss;
                legal = int'(f3 <= 2);
            end
            7'h13: begin
                src2 = 1; writes = 1; aluop = f3; uses1 = 1; imm = ii;
                if (f3 == 1) legal = int'(f7 == 0);
                else if (f3 == 5) begin
                    legal = int'(f7 == 0 || f7 == 32);
                    arith = (f7 >> 5) & 1;
                end
            end
            7'h33: begin
                writes = 1; aluop = f3; arith = (f7 >> 5) & 1; uses1 = 1; uses2 = 1;
                legal = int'(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
            end
            default: known = 0;
        endcase
        e = '0;
        e.pc = p;
        if (known != 0 && legal != 0) begin
            wr_rd = (writes != 0 && rd != 0) ? 1 : 0;
            c = (src1 << 17) | (src2 << 16) | (aluop << 13) | (arith << 12) |
                ((wr_rd != 0 ? rd : 0) << 7) | (mrd << 6) | (mwr << 5) | (lsf3 << 2) |
                (wr_rd << 1) | mrd;
            e.ctrl   = 18'(c);
            e.imm    = imm;
            e.branch = (br != 0);
            e.jump   = (jmp != 0);
        end else begin
            e.illegal = 1'b1;
        end
        e.rs1 = (uses1 != 0) ? w[19:15] : 5'd0;
        e.rs2 = (uses2 != 0) ? w[24:20] : 5'd0;
        return e;
    endfunction

    task automatic compare_dut(input string m, input bit exp_rdy, input bit exp_vld,
                               input exp_t e, input logic g_rdy, input logic g_vld, input exp_t g);
        check({m, ".in_ready"}, 64'(g_rdy), 64'(exp_rdy));
        check({m, ".out_valid"}, 64'(g_vld), 64'(exp_vld));
        if (exp_vld) begin
            check({m, ".ctrl"}, 64'(g.ctrl), 64'(e.ctrl));
            check({m, ".imm"}, 64'(g.imm), 64'(e.imm));
            check({m, ".pc"}, 64'(g.pc), 64'(e.pc));
            check({m, ".branch"}, 64'(g.branch), 64'(e.branch));
            check({m, ".jump"}, 64'(g.jump), 64'(e.jump));
            check({m, ".illegal"}, 64'(g.illegal), 64'(e.illegal));
            if (!e.illegal) begin
                check({m, ".rs1"}, 64'(g.rs1), 64'(e.rs1));
                check({m, ".rs2"}, 64'(g.rs2), 64'(e.rs2));
            end
        end
    endtask

    task automatic compare_all();
        exp_t e1, e0;
        e1 = (q1.size() > 0) ? q1[0] : exp_t'('0);
        e0 = (q0.size() > 0) ? q0[0] : exp_t'('0);
        compare_dut("skid", q1.size() < 2, q1.size() > 0, e1, rdy1, vld1,
                    exp_t'{ctrl1, rs1_1, rs2_1, imm1, pc1, br1, jp1, il1});
        compare_dut("single", (q0.size() == 0) || out_ready, q0.size() > 0, e0, rdy0, vld0,
                    exp_t'{ctrl0, rs1_0, rs2_0, imm0, pc0, br0, jp0, il0});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".skid.valid"}, 64'(vld1), 64'(0));
        check({tag, ".skid.ready"}, 64'(rdy1), 64'(1));
        check({tag, ".skid.data"}, 64'({ctrl1, rs1_1, rs2_1, br1, jp1, il1}), 64'(0));
        check({tag, ".skid.imm_pc"}, {imm1, 16'h0, pc1}, 64'(0));
        check({tag, ".single.valid"}, 64'(vld0), 64'(0));
        check({tag, ".single.ready"}, 64'(rdy0), 64'(1));
        check({tag, ".single.data"}, 64'({ctrl0, rs1_0, rs2_0, br0, jp0, il0}), 64'(0));
        check({tag, ".single.imm_pc"}, {imm0, 16'h0, pc0}, 64'(0));
    endtask

    // One clock: inputs are already driven; model advances on the edge, outputs checked at negedge.
    task automatic cycle();
        bit r1, r0, c1, c0;
        r1 = q1.size() < 2;
        r0 = (q0.size() == 0) || out_ready;
        acc1_last = in_valid && r1;
        acc0_last = in_valid && r0;
        c1 = (q1.size() > 0) && out_ready;
        c0 = (q0.size() > 0) && out_ready;
        if (vld1 && out_ready) obs1.push_back(pc1);
        if (vld0 && out_ready) obs0.push_back(pc0);
        @(posedge clk);
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (c1) void'(q1.pop_front());
            if (c0) void'(q0.pop_front());
            if (acc1_last) q1.push_back(ref_decode(instr, pc));
            if (acc0_last) q0.push_back(ref_decode(instr, pc));
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_one(input logic [31:0] w, input logic [15:0] p);
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; instr = w; pc = p;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (n) cycle();
    endtask

    task automatic stream_test(input bit skid_mode);
        logic [31:0] words[4];
        logic [15:0] pcs[4];
        int          idx, cyc;
        string       m;
        m = skid_mode ? "stream.skid" : "stream.single";
        for (int i = 0; i < 4; i++) begin
            words[i] = (32'(i + 7) << 20) | (32'(i + 1) << 7) | 32'h13;
            pcs[i]   = 16'h0100 + 16'(i * 4);
        end
        obs1.delete();
        obs0.delete();
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            if (cyc == 3) begin
                if (skid_mode) begin
                    check({m, ".ready_stalled"}, 64'(rdy1), 64'(0));
                    check({m, ".head_pc"}, 64'(pc1), 64'(pcs[0]));
                end else begin
                    check({m, ".ready_stalled"}, 64'(rdy0), 64'(0));
                    check({m, ".head_pc"}, 64'(pc0), 64'(pcs[0]));
                end
            end
            flush = 1'b0;
            out_ready = (cyc >= 3);
            in_valid = 1'b1;
            instr = words[idx];
            pc = pcs[idx];
            cycle();
            if (skid_mode ? acc1_last : acc0_last) idx++;
            cyc++;
        end
        check({m, ".all_sent"}, 64'(idx), 64'(4));
        drain(4);
        if (skid_mode) begin
            check({m, ".delivered"}, 64'(obs1.size()), 64'(4));
            for (int i = 0; i < 4 && i < obs1.size(); i++) check({m, ".order"}, 64'(obs1[i]), 64'(pcs[i]));
        end else begin
            check({m, ".delivered"}, 64'(obs0.size()), 64'(4));
            for (int i = 0; i < 4 && i < obs0.size(); i++) check({m, ".order"}, 64'(obs0[i]), 64'(pcs[i]));
        end
    endtask

    function automatic logic [31:0] gen_word();
        logic [6:0]  ops[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(9) != 0) begin
            w[6:0] = ops[$urandom_range(8)];
            if ($urandom_range(1) != 0) w[31:25] = ($urandom_range(1) != 0) ? 7'h20 : 7'h00;
        end
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        send_one(32'hFFF0_0093, 16'h0010);
        check("addi.imm", 64'(imm1), 64'hFFFF_FFFF);
        check("addi.ctrl", 64'(ctrl1), 64'h1_0082);
        send_one(32'h4020_81B3, 16'h0014);
        check("sub.rs1", 64'(rs1_1), 64'(1));
        check("sub.rs2", 64'(rs2_1), 64'(2));
        check("sub.ctrl", 64'(ctrl1), 64'h0_1182);
        send_one(32'hFE00_0EE3, 16'h0018);
        check("beq.imm", 64'(imm1), 64'hFFFF_FFFC);
        check("beq.branch", 64'(br1), 64'(1));
        check("beq.ctrl", 64'(ctrl1), 64'(0));
        send_one(32'h0080_00EF, 16'h001C);
        check("jal.imm", 64'(imm1), 64'(8));
        check("jal.jump", 64'(jp1), 64'(1));
        check("jal.ctrl", 64'(ctrl1), 64'h3_0082);
        send_one(32'h0000_007F, 16'h0020);
        check("bad_op.illegal", 64'(il1), 64'(1));
        check("bad_op.ctrl", 64'(ctrl1), 64'(0));
        send_one(32'h4000_9093, 16'h0024);
        check("slli_f7.illegal", 64'(il1), 64'(1));
        check("slli_f7.ctrl_imm", {14'h0, ctrl1, imm1}, 64'(0));
        send_one(32'h0000_7083, 16'h0028);
        check("lw_f3.illegal", 64'(il1), 64'(1));
        check("lw_f3.ctrl", 64'(ctrl1), 64'(0));
        drain(3);

        stream_test(1'b1);
        stream_test(1'b0);

        // Flush with both skid entries full and a word offered in the same cycle.
        obs1.delete();
        obs0.delete();
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h0010_0093; pc = 16'h0200; cycle();
        instr = 32'h0020_0113; pc = 16'h0204; cycle();
        flush = 1'b1; instr = 32'h0030_0193; pc = 16'h02F0; cycle();
        check("flush.skid.valid", 64'(vld1), 64'(0));
        check("flush.skid.ready", 64'(rdy1), 64'(1));
        check("flush.single.valid", 64'(vld0), 64'(0));
        check("flush.single.ready", 64'(rdy0), 64'(1));
        drain(4);
        check("flush.skid.nothing_delivered", 64'(obs1.size()), 64'(0));
        check("flush.single.nothing_delivered", 64'(obs0.size()), 64'(0));

        // Asynchronous reset in the middle of a stall, away from any clock edge.
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h0040_0213; pc = 16'h0280; cycle();
        instr = 32'h0050_0293; pc = 16'h0284; cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_rst");
        q1.delete();
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_one(32'h0050_0113, 16'h0300);
        check("post_rst.imm", 64'(imm1), 64'(5));
        check("post_rst.ctrl", 64'(ctrl1), 64'h1_0102);
        check("post_rst.pc", 64'(pc1), 64'h0300);

        for (int i = 0; i < 1500; i++) begin
            flush     = ($urandom_range(39) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            instr     = gen_word();
            pc        = 16'($urandom);
            cycle();
        end
        drain(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
